uart_tx_arbiter: RTL

//  Shares the ring UART transmit path between NUM_REQ byte-stream requesters (CPU console, debug

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding NUM_REQ byte streams into a ring UART TX buffer via its register port.
// Optional UART_ARB_TAG_EN: each grant starts with a tag byte 8'hF0 | grant_id.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int RING_SIZE_TX = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   uart_state_re,
  input  logic [31:0]            uart_state_do,
  output logic                   uart_dat_we,
  output logic [31:0]            uart_dat_di,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND, S_SETTLE} state_t;

  localparam logic [7:0]              MAX_B    = 8'(MAX_BURST);
  localparam logic [3:0]              NREQ4    = 4'(NUM_REQ);
  localparam logic [2:0]              LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [RING_SIZE_TX-1:0] ONE_R    = 1;

  state_t     state;
  logic [2:0] rr;
  logic [7:0] burst;
  logic       last_seen;

  logic [7:0]            rv_ext, last_ext, ready_ext;
  logic [63:0]           data_ext;
  logic                  pick_found;
  logic [2:0]            pick_idx, rr_next;
  logic [3:0]            cand_sum;
  logic [2:0]            cand;
  logic [RING_SIZE_TX-1:0] head, tail, tail_nxt;
  logic                  full;
  logic                  tag_now;
  logic                  owner_valid, owner_last;
  logic [7:0]            owner_byte, wr_byte;
  logic                  send_ok;
  logic                  unused_status;

`ifdef UART_ARB_TAG_EN
  logic tag_pending;
  assign tag_now = tag_pending;
`else
  assign tag_now = 1'b0;
`endif

  // Only the low RING_SIZE_TX bits of each pointer matter; the modulo compare covers wrap-around.
  assign head          = uart_state_do[21 +: RING_SIZE_TX];
  assign tail          = uart_state_do[14 +: RING_SIZE_TX];
  assign tail_nxt      = tail + ONE_R;
  assign full          = (tail_nxt == head);
  assign unused_status = ^uart_state_do;

  always_comb begin
    rv_ext   = '0;
    last_ext = '0;
    data_ext = '0;
    rv_ext[NUM_REQ-1:0]     = req_valid;
    last_ext[NUM_REQ-1:0]   = req_last;
    data_ext[8*NUM_REQ-1:0] = req_data;

    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr} + 4'(k);
      if (cand_sum >= NREQ4) cand_sum = cand_sum - NREQ4;
      cand = cand_sum[2:0];
      if (!pick_found && rv_ext[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    rr_next = (pick_idx == LAST_IDX) ? 3'd0 : pick_idx + 3'd1;

    owner_valid = rv_ext[grant_id];
    owner_last  = last_ext[grant_id];
    owner_byte  = data_ext[{grant_id, 3'b000} +: 8];
    wr_byte     = tag_now ? (8'hF0 | {5'b0, grant_id}) : owner_byte;

    send_ok   = resetn && (state == S_SEND) && !full && (tag_now || owner_valid);
    ready_ext = '0;
    if (send_ok && !tag_now) ready_ext[grant_id] = 1'b1;
  end

  assign req_ready     = ready_ext[NUM_REQ-1:0];
  assign uart_dat_we   = send_ok;
  assign uart_dat_di   = send_ok ? {24'b0, wr_byte} : 32'b0;
  assign uart_state_re = busy;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      rr        <= '0;
      burst     <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      last_seen <= 1'b0;
`ifdef UART_ARB_TAG_EN
      tag_pending <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (|req_valid) state <= S_ARB;
        S_ARB: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            burst    <= '0;
            rr       <= rr_next;
            state    <= S_SEND;
`ifdef UART_ARB_TAG_EN
            tag_pending <= 1'b1;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (send_ok) begin
            state <= S_SETTLE;
            if (tag_now) begin
              last_seen <= 1'b0;
`ifdef UART_ARB_TAG_EN
              tag_pending <= 1'b0;
`endif
            end else begin
              burst     <= burst + 8'd1;
              last_seen <= owner_last;
            end
          end
        end
        S_SETTLE: begin
          // The ring tail pointer catches up during this cycle before the next write.
          if (last_seen || burst == MAX_B) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
